// File: rtl/dvp_capture_rgb565.sv
// -----------------------------------------------------------------------------
// dvp_capture_rgb565
//
// Camera-side capture stage for the OV5640 path. Samples the 8-bit DVP bus
// (VSYNC / HREF / D[7:0]) on PCLK and packs byte pairs into RGB565 pixels
// that are written into the input FIFO drained by control_frame_buffer. The
// block also measures the active frame geometry (pixels per line, lines per
// frame) and presents it to the frame-buffer controller once per frame.
//
// Parameters:
//   DATA_WIDTH         pixel word width, RGB565 only (16)
//   VSYNC_ACTIVE_HIGH  1: VSYNC high during blanking, 0: inverted polarity
//   MAX_DIM_WIDTH      width of the pixel/line counters (<= 16)
//
// Ports:
//   clk_i               camera PCLK, the only clock (rising edge)
//   resetn_i            asynchronous active-low reset
//   vsync_i             DVP frame sync
//   href_i              DVP line valid
//   data_i [7:0]        DVP data byte
//   full_i              input FIFO full
//   wr_o                FIFO write strobe, one cycle per pixel
//   data_o [15:0]       pixel {first_byte, second_byte}
//   resolution_width_o  pixels per line of the last completed frame
//   resolution_depth_o  lines of the last completed frame
//   frame_done_o        one-cycle pulse when a frame completes
//   overflow_o          sticky, a pixel was lost to full_i
//
// Optional feature (compile-time macro):
//   DVP_FRAME_DECIMATE_EN  when defined, only every other frame is written to
//                          the FIFO; geometry and frame_done_o still follow
//                          every frame.
// -----------------------------------------------------------------------------
module dvp_capture_rgb565 #(
  parameter int DATA_WIDTH        = 16,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
  parameter int MAX_DIM_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  vsync_i,
  input  logic                  href_i,
  input  logic [7:0]            data_i,
  input  logic                  full_i,
  output logic                  wr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           resolution_width_o,
  output logic [15:0]           resolution_depth_o,
  output logic                  frame_done_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  // The vsync pipeline resets to the blanking-inactive level so that a reset
  // released in the middle of an active frame never looks like a frame start.
  localparam logic VS_IDLE = !VSYNC_ACTIVE_HIGH;
  localparam logic [MAX_DIM_WIDTH-1:0] DIM_ONE = MAX_DIM_WIDTH'(1);

  // Counters saturate at all-ones instead of wrapping.
  function automatic logic [MAX_DIM_WIDTH-1:0] sat_inc(input logic [MAX_DIM_WIDTH-1:0] value);
    return (&value) ? value : value + DIM_ONE;
  endfunction

  logic                     vsync_q;
  logic                     href_q;
  logic [7:0]               data_q;
  logic                     vsync_d;
  logic                     href_d;

  logic                     vs_active;
  logic                     vs_active_d;
  logic                     vs_assert;
  logic                     vs_deassert;
  logic                     href_rise;
  logic                     href_fall;

  logic                     phase_q;
  logic                     byte_phase;
  logic [7:0]               high_byte_q;
  logic                     pixel_done;

  state_t                   state_q;
  state_t                   state_d;
  logic                     frame_start;
  logic                     frame_end;
  logic                     pixel_write;
  logic                     pixel_lost;
  logic                     frame_written;

  logic [MAX_DIM_WIDTH-1:0] pix_cnt_q;
  logic [MAX_DIM_WIDTH-1:0] line_width_q;
  logic [MAX_DIM_WIDTH-1:0] line_cnt_q;
  logic                     line_counted;
  logic [MAX_DIM_WIDTH-1:0] line_cnt_next;
  logic [MAX_DIM_WIDTH-1:0] width_now;

  // Single input register stage for the whole DVP bus, plus a second delayed
  // copy of the sync signals used only for edge detection.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vsync_q <= VS_IDLE;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      vsync_d <= VS_IDLE;
      href_d  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
      data_q  <= data_i;
      vsync_d <= vsync_q;
      href_d  <= href_q;
    end
  end

  assign vs_active   = (vsync_q == VSYNC_ACTIVE_HIGH);
  assign vs_active_d = (vsync_d == VSYNC_ACTIVE_HIGH);
  assign vs_assert   = vs_active & ~vs_active_d;
  assign vs_deassert = ~vs_active & vs_active_d;
  assign href_rise   = href_q & ~href_d;
  assign href_fall   = ~href_q & href_d;

  // The first byte of every line is always a high byte, even if the previous
  // line ended on an odd byte, so the phase is forced to 0 on HREF rise.
  assign byte_phase = href_rise ? 1'b0 : phase_q;
  assign pixel_done = href_q & byte_phase;

  // Byte phase tracking and high-byte holding register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      phase_q     <= 1'b0;
      high_byte_q <= 8'h00;
    end else begin
      if (href_q) begin
        phase_q <= ~byte_phase;
        if (!byte_phase) begin
          high_byte_q <= data_q;
        end
      end else begin
        phase_q <= 1'b0;
      end
    end
  end

`ifdef DVP_FRAME_DECIMATE_EN
  logic skip_q;
  logic frame_close;

  // Any frame that reached FRAME counts for decimation, including frames that
  // were abandoned in DROP, so the written/skipped cadence stays regular.
  assign frame_close = vs_assert & ((state_q == FRAME) | (state_q == DROP));

  // Decimation toggle: frames seen with the toggle set are measured but not
  // written to the FIFO.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      skip_q <= 1'b0;
    end else if (frame_close) begin
      skip_q <= ~skip_q;
    end
  end

  assign frame_written = ~skip_q;
`else
  assign frame_written = 1'b1;
`endif

  // Frame state register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control decode. A pixel lost to full_i abandons
  // the frame; if that coincides with VSYNC assertion the frame still closes
  // without publishing geometry.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pixel_write = 1'b0;
    pixel_lost  = 1'b0;
    case (state_q)
      SYNC: begin
        if (vs_deassert) begin
          state_d     = FRAME;
          frame_start = 1'b1;
        end
      end
      FRAME: begin
        if (pixel_done && frame_written) begin
          if (full_i) begin
            pixel_lost = 1'b1;
          end else begin
            pixel_write = 1'b1;
          end
        end
        if (vs_assert) begin
          state_d   = SYNC;
          frame_end = ~pixel_lost;
        end else if (pixel_lost) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (vs_assert) begin
          state_d = SYNC;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // Pack register and FIFO-side status. data_o holds the last written pixel
  // between strobes.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_o         <= 1'b0;
      data_o       <= '0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      wr_o         <= pixel_write;
      frame_done_o <= frame_end;
      if (pixel_write) begin
        data_o <= DATA_WIDTH'({high_byte_q, data_q});
      end
      if (pixel_lost) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // A line that ends in the same registered cycle as VSYNC assertion must
  // still be counted, so the frame-end latch uses these look-ahead values.
  assign line_counted  = href_fall & (state_q == FRAME);
  assign line_cnt_next = line_counted ? sat_inc(line_cnt_q) : line_cnt_q;
  assign width_now     = href_fall ? pix_cnt_q : line_width_q;

  // Pixel counter per line and the width captured at the end of each line.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pix_cnt_q    <= '0;
      line_width_q <= '0;
    end else begin
      if (href_rise) begin
        pix_cnt_q <= '0;
      end else if (pixel_done) begin
        pix_cnt_q <= sat_inc(pix_cnt_q);
      end
      if (href_fall) begin
        line_width_q <= pix_cnt_q;
      end
    end
  end

  // Line counter for the frame currently being captured.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      line_cnt_q <= '0;
    end else if (frame_start) begin
      line_cnt_q <= '0;
    end else begin
      line_cnt_q <= line_cnt_next;
    end
  end

  // Geometry outputs change only at a clean frame end, together with the
  // frame_done_o pulse.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      resolution_width_o <= 16'h0000;
      resolution_depth_o <= 16'h0000;
    end else if (frame_end) begin
      resolution_width_o <= 16'(width_now);
      resolution_depth_o <= 16'(line_cnt_next);
    end
  end

endmodule

// File: tb/tb_dvp_capture_rgb565.sv
// -----------------------------------------------------------------------------
// tb_dvp_capture_rgb565
//
// Drives DVP frames into two instances of dvp_capture_rgb565: one with the
// default VSYNC polarity and one with inverted polarity fed the inverted
// VSYNC, so both should behave identically. Expected pixels are pushed into
// a per-instance queue as bytes are driven and popped as wr_o fires.
// -----------------------------------------------------------------------------
module tb_dvp_capture_rgb565;

  localparam int NUM_DUT = 2;

  typedef struct {
    int n_bytes;
    int lines;
    int full_pix;
    int reset_line;
    int tail_gap;
    int exp_writes;
    int exp_done;
    int exp_width;
    int exp_depth;
    int exp_ovf;
  } frame_rec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vsync;
  logic        href;
  logic        full;
  logic [7:0]  data;

  logic        wr     [NUM_DUT];
  logic [15:0] dout   [NUM_DUT];
  logic [15:0] width  [NUM_DUT];
  logic [15:0] depth  [NUM_DUT];
  logic        done   [NUM_DUT];
  logic        ovf    [NUM_DUT];

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q [NUM_DUT][$];
  int          write_cnt [NUM_DUT] = '{0, 0};
  int          done_cnt  [NUM_DUT] = '{0, 0};
  logic        prev_wr   [NUM_DUT] = '{1'b0, 1'b0};
  bit          m_toggle = 1'b0;

  always #5 clk = ~clk;

  dvp_capture_rgb565 #(
    .DATA_WIDTH(16),
    .VSYNC_ACTIVE_HIGH(1'b1),
    .MAX_DIM_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .resetn_i(resetn),
    .vsync_i(vsync),
    .href_i(href),
    .data_i(data),
    .full_i(full),
    .wr_o(wr[0]),
    .data_o(dout[0]),
    .resolution_width_o(width[0]),
    .resolution_depth_o(depth[0]),
    .frame_done_o(done[0]),
    .overflow_o(ovf[0])
  );

  dvp_capture_rgb565 #(
    .DATA_WIDTH(16),
    .VSYNC_ACTIVE_HIGH(1'b0),
    .MAX_DIM_WIDTH(16)
  ) dut_inv (
    .clk_i(clk),
    .resetn_i(resetn),
    .vsync_i(~vsync),
    .href_i(href),
    .data_i(data),
    .full_i(full),
    .wr_o(wr[1]),
    .data_o(dout[1]),
    .resolution_width_o(width[1]),
    .resolution_depth_o(depth[1]),
    .frame_done_o(done[1]),
    .overflow_o(ovf[1])
  );

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one PCLK slot, away from the rising edge.
  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d,
                               input logic fl, input logic rn);
    @(posedge clk);
    #2;
    vsync  = vs;
    href   = hr;
    data   = d;
    full   = fl;
    resetn = rn;
  endtask

  // Checks that every output of both instances is at its reset value.
  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("%s_wr[%0d]", tag, i), int'(wr[i]), 0);
      checkOutput($sformatf("%s_data[%0d]", tag, i), int'(dout[i]), 0);
      checkOutput($sformatf("%s_width[%0d]", tag, i), int'(width[i]), 0);
      checkOutput($sformatf("%s_depth[%0d]", tag, i), int'(depth[i]), 0);
      checkOutput($sformatf("%s_done[%0d]", tag, i), int'(done[i]), 0);
      checkOutput($sformatf("%s_ovf[%0d]", tag, i), int'(ovf[i]), 0);
    end
  endtask

  function automatic bit model_written();
`ifdef DVP_FRAME_DECIMATE_EN
    return (m_toggle == 1'b0);
`else
    return 1'b1;
`endif
  endfunction

  // Write monitor: pops the scoreboard on every strobe and checks strobe spacing.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_DUT; i++) begin
      if (wr[i]) begin
        write_cnt[i]++;
        checkOutput($sformatf("wr_back_to_back[%0d]", i), int'(prev_wr[i]), 0);
        if (exp_q[i].size() == 0) begin
          checkOutput($sformatf("unexpected_write[%0d]", i), 1, 0);
        end else begin
          checkOutput($sformatf("pixel[%0d]", i), int'(dout[i]), int'(exp_q[i].pop_front()));
        end
      end
      prev_wr[i] = wr[i];
      if (done[i]) begin
        done_cnt[i]++;
      end
    end
  end

  // Sends one frame: blanking, active lines, VSYNC assertion, trailing blanking.
  task automatic run_frame(input frame_rec_t r, input bit written, input string tag);
    int          w0 [NUM_DUT];
    int          d0 [NUM_DUT];
    int          gb;
    int          pair;
    bit          ovf_hit;
    bit          reset_seen;
    logic [7:0]  byte_val;
    logic [7:0]  hi_val;
    logic        fl;
    logic        rn;
    int          exp_w;

    for (int i = 0; i < NUM_DUT; i++) begin
      w0[i] = write_cnt[i];
      d0[i] = done_cnt[i];
    end
    gb = 0;
    pair = 0;
    ovf_hit = 1'b0;
    reset_seen = 1'b0;
    hi_val = 8'h00;

    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    for (int l = 0; l < r.lines; l++) begin
      for (int b = 0; b < r.n_bytes; b++) begin
        rn = 1'b1;
        if (l == r.reset_line && b >= 8 && b <= 10) begin
          rn = 1'b0;
        end
        fl = (r.full_pix >= 0) && (gb == 2 * r.full_pix + 1 || gb == 2 * r.full_pix + 2);
        if ((b % 2) == 0) begin
          if (b == r.n_bytes - 1) begin
            byte_val = 8'hEE;
          end else begin
            hi_val   = 8'hA0 + 8'(pair);
            byte_val = hi_val;
          end
        end else begin
          byte_val = 8'h50 + 8'(pair);
        end
        applyStimulus(1'b0, 1'b1, byte_val, fl, rn);
        if (!rn && !reset_seen) begin
          reset_seen = 1'b1;
          for (int i = 0; i < NUM_DUT; i++) begin
            exp_q[i].delete();
          end
        end
        if (l == r.reset_line && b == 9) begin
          checkResetOutputs({tag, "_midreset"});
        end
        if ((b % 2) == 1) begin
          if (written && !ovf_hit && !reset_seen) begin
            if (pair == r.full_pix) begin
              ovf_hit = 1'b1;
            end else begin
              for (int i = 0; i < NUM_DUT; i++) begin
                exp_q[i].push_back({hi_val, byte_val});
              end
            end
          end
          pair++;
        end
        gb++;
      end
      if (l < r.lines - 1) begin
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      end
    end

    repeat (r.tail_gap) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("%s_done_early[%0d]", tag, i), int'(done[i]), 0);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("%s_done_timing[%0d]", tag, i), int'(done[i]), r.exp_done);
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    exp_w = written ? r.exp_writes : 0;
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("%s_writes[%0d]", tag, i), write_cnt[i] - w0[i], exp_w);
      checkOutput($sformatf("%s_done_count[%0d]", tag, i), done_cnt[i] - d0[i], r.exp_done);
      checkOutput($sformatf("%s_width[%0d]", tag, i), int'(width[i]), r.exp_width);
      checkOutput($sformatf("%s_depth[%0d]", tag, i), int'(depth[i]), r.exp_depth);
      checkOutput($sformatf("%s_overflow[%0d]", tag, i), int'(ovf[i]), r.exp_ovf);
      checkOutput($sformatf("%s_pending[%0d]", tag, i), exp_q[i].size(), 0);
    end

    if (reset_seen) begin
      m_toggle = 1'b0;
    end else begin
      m_toggle = ~m_toggle;
    end
  endtask

  initial begin
    frame_rec_t vec_tbl [8];
    frame_rec_t filler;
    frame_rec_t big;
    int         w_before [NUM_DUT];
    int         d_before [NUM_DUT];

    //                n_bytes lines full rst tail writes done  w   d  ovf
    vec_tbl[0] = '{16, 4, -1, -1, 3, 32, 1, 8, 4, 0};
    vec_tbl[1] = '{17, 4, -1, -1, 3, 32, 1, 8, 4, 0};
    vec_tbl[2] = '{16, 4,  4, -1, 3,  4, 0, 8, 4, 1};
    vec_tbl[3] = '{16, 4, -1, -1, 3, 32, 1, 8, 4, 1};
    vec_tbl[4] = '{16, 3, -1, -1, 0, 24, 1, 8, 3, 1};
    vec_tbl[5] = '{16, 0, -1, -1, 3,  0, 1, 8, 0, 1};
    vec_tbl[6] = '{16, 4, -1,  1, 3, 11, 0, 0, 0, 0};
    vec_tbl[7] = '{16, 4, -1, -1, 3, 32, 1, 8, 4, 0};

    resetn = 1'b0;
    vsync  = 1'b0;
    href   = 1'b0;
    full   = 1'b0;
    data   = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");

    // Reset released mid-frame: the partial frame must be ignored entirely.
    for (int i = 0; i < NUM_DUT; i++) begin
      w_before[i] = write_cnt[i];
      d_before[i] = done_cnt[i];
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(1'b0, 1'b1, 8'(8'h11 + b), 1'b0, 1'b1);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("partial_writes[%0d]", i), write_cnt[i] - w_before[i], 0);
      checkOutput($sformatf("partial_done[%0d]", i), done_cnt[i] - d_before[i], 0);
    end

    for (int t = 0; t < 8; t++) begin
      run_frame(vec_tbl[t], model_written(), $sformatf("row%0d", t));
`ifdef DVP_FRAME_DECIMATE_EN
      if (m_toggle) begin
        filler = '{16, 4, -1, -1, 3, 32, 1, 8, 4, vec_tbl[t].exp_ovf};
        run_frame(filler, model_written(), $sformatf("skip%0d", t));
      end
`endif
    end

    // Four back-to-back frames; with decimation only the 1st and 3rd are written.
    filler = '{16, 4, -1, -1, 3, 32, 1, 8, 4, 0};
    for (int f = 0; f < 4; f++) begin
      run_frame(filler, model_written(), $sformatf("burst%0d", f));
    end

    // Long lines: 640 pixels by 2 lines, seen through both VSYNC polarities.
    big = '{1280, 2, -1, -1, 3, 1280, 1, 640, 2, 0};
    run_frame(big, model_written(), "vga_line");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
